cpc_fifo_host_ctrl: RTL and testbench

- CPLD-resident controller that sequences the host-side port of the CPC↔Pi FIFO pair from Z80 I/O cycles.
- Decodes a data port and a status/control port.
- Generates the FIFO SI, SOB, OEB and MR strobes with the required pulse widths.
- Returns synchronised DIR/DOR status and sticky error flags to the CPC.

---
 rtl/cpc_fifo_host_ctrl_pkg.sv | 25 ++
 rtl/cpc_fifo_host_ctrl_if.sv | 17 +
 rtl/cpc_sync2.sv | 25 ++
 rtl/cpc_fifo_host_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_cpc_fifo_host_ctrl.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpc_fifo_host_ctrl_pkg.sv
// Shared types and constants for the CPC host-side FIFO controller.
package cpc_fifo_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_SI   = 3'd1,
    RD_DATA = 3'd2,
    RD_SOB  = 3'd3,
    RD_STAT = 3'd4,
    RST     = 3'd5,
    DONE    = 3'd6
  } state_e;

  // Status byte layout returned on the status/control port
  localparam int STAT_DOR = 0;
  localparam int STAT_DIR = 1;
  localparam int STAT_UNF = 6;
  localparam int STAT_OVF = 7;

  // Control write bit that fires a FIFO master reset
  localparam int CTRL_RST_BIT = 7;

  localparam logic [15:0] DEF_BASE_ADDR = 16'hFD80;

endpackage

// File: rtl/cpc_fifo_host_ctrl_if.sv
// Z80 I/O bus as seen by the FIFO controller.
// master = CPU side, slave = controller side.
interface cpc_fifo_host_ctrl_if;
  logic [15:0] A;
  logic [7:0]  D_IN;
  logic [7:0]  D_OUT;
  logic        D_OE;
  logic        IOREQ_B;
  logic        RD_B;
  logic        WR_B;
  logic        READY;

  modport master (output A, D_IN, IOREQ_B, RD_B, WR_B,
                  input  D_OUT, D_OE, READY);
  modport slave  (input  A, D_IN, IOREQ_B, RD_B, WR_B,
                  output D_OUT, D_OE, READY);
endinterface

// File: rtl/cpc_sync2.sv
// Generic 2-flop synchroniser with a parameterised reset value.
module cpc_sync2 #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two-stage capture of an asynchronous input, synchronous reset
  always_ff @(posedge gclk) begin
    if (!grst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cpc_fifo_host_ctrl.sv
// Host-side sequencer for the CPC<->Pi FIFO pair, driven by Z80 I/O cycles.
// Data port at BASE_ADDR, status/control port at BASE_ADDR+1.
// Optional macro CPC_FIFO_WAIT_EN: stall the Z80 via READY while the FIFO
// is full (write) or empty (read), for up to 255 cycles.
module cpc_fifo_host_ctrl
  import cpc_fifo_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = DEF_BASE_ADDR,
  parameter int          SI_CYCLES  = 2,
  parameter int          SOB_CYCLES = 2,
  parameter int          RST_CYCLES = 4
) (
  input  logic                 CLK,
  input  logic                 RESET_B,
  cpc_fifo_host_ctrl_if.slave  bus,
  input  logic                 fifo_host_dir,
  input  logic                 fifo_host_dor,
  output logic                 host_fifo_si,
  output logic                 host_fifo_sob,
  output logic                 host_fifo_oeb,
  output logic                 host_fifo_reset
);

  logic [2:0] strb_s;
  logic [1:0] flag_s;
  logic       iorq_s, rd_s, wr_s, dir_s, dor_s;

  cpc_sync2 #(.W(3), .RST_VAL(3'b111)) u_sync_strb (
    .gclk   (CLK),
    .grst_n (RESET_B),
    .d      ({bus.IOREQ_B, bus.RD_B, bus.WR_B}),
    .q      (strb_s)
  );

  cpc_sync2 #(.W(2), .RST_VAL(2'b00)) u_sync_flag (
    .gclk   (CLK),
    .grst_n (RESET_B),
    .d      ({fifo_host_dir, fifo_host_dor}),
    .q      (flag_s)
  );

  assign iorq_s = strb_s[2];
  assign rd_s   = strb_s[1];
  assign wr_s   = strb_s[0];
  assign dir_s  = flag_s[1];
  assign dor_s  = flag_s[0];

  logic start, sel_data, sel_stat, is_wr;
  assign start    = !iorq_s && (!rd_s || !wr_s);
  assign sel_data = (bus.A == BASE_ADDR);
  assign sel_stat = (bus.A == (BASE_ADDR | 16'h0001));
  assign is_wr    = !wr_s;

  state_e     state;
  logic [7:0] cnt;
  logic [7:0] mr_cnt;
  logic       ovf, unf;
  logic       d_oe_q;
  logic [7:0] d_out_q;
  logic [7:0] stat_byte;

  // Status byte as seen at RD_STAT entry
  always_comb begin
    stat_byte           = '0;
    stat_byte[STAT_OVF] = ovf;
    stat_byte[STAT_UNF] = unf;
    stat_byte[STAT_DIR] = dir_s;
    stat_byte[STAT_DOR] = dor_s;
  end

`ifdef CPC_FIFO_WAIT_EN
  logic       ready_q;
  logic [7:0] wcnt;
  assign bus.READY = ready_q;
`else
  assign bus.READY = 1'b1;
`endif

  assign bus.D_OUT = d_out_q;
  assign bus.D_OE  = d_oe_q;

  // Access sequencer: one FIFO action per I/O cycle, plus MR pulse timer
  always_ff @(posedge CLK) begin
    if (!RESET_B) begin
      state           <= IDLE;
      cnt             <= '0;
      mr_cnt          <= 8'(RST_CYCLES);
      host_fifo_reset <= 1'b1;
      host_fifo_si    <= 1'b0;
      host_fifo_sob   <= 1'b1;
      host_fifo_oeb   <= 1'b1;
      d_oe_q          <= 1'b0;
      d_out_q         <= '0;
      ovf             <= 1'b0;
      unf             <= 1'b0;
`ifdef CPC_FIFO_WAIT_EN
      ready_q         <= 1'b1;
      wcnt            <= '0;
`endif
    end else begin
      // MR stays high while the timer is non-zero; RST reloads it
      if (mr_cnt != 8'd0) mr_cnt <= mr_cnt - 8'd1;
      host_fifo_reset <= (mr_cnt != 8'd0);

      case (state)
        IDLE: begin
`ifdef CPC_FIFO_WAIT_EN
          ready_q <= 1'b1;
          wcnt    <= '0;
`endif
          if (start) begin
            if (sel_data && is_wr) begin
              if (dir_s) begin
                host_fifo_si <= 1'b1;
                cnt          <= 8'(SI_CYCLES - 1);
                state        <= WR_SI;
              end
`ifdef CPC_FIFO_WAIT_EN
              // Hold the Z80 and re-evaluate next cycle
              else if (wcnt != 8'hFF) begin
                ready_q <= 1'b0;
                wcnt    <= wcnt + 8'd1;
              end
`endif
              else begin
                ovf   <= 1'b1;
                state <= DONE;
              end
            end else if (sel_data) begin
              if (dor_s) begin
                host_fifo_oeb <= 1'b0;
                state         <= RD_DATA;
              end
`ifdef CPC_FIFO_WAIT_EN
              else if (wcnt != 8'hFF) begin
                ready_q <= 1'b0;
                wcnt    <= wcnt + 8'd1;
              end
`endif
              else begin
                // Empty FIFO: float-high byte from us, FIFO stays off the bus
                unf     <= 1'b1;
                d_oe_q  <= 1'b1;
                d_out_q <= 8'hFF;
                state   <= DONE;
              end
            end else if (sel_stat && is_wr) begin
              if (bus.D_IN[CTRL_RST_BIT]) begin
                mr_cnt          <= 8'(RST_CYCLES - 1);
                host_fifo_reset <= 1'b1;
                ovf             <= 1'b0;
                unf             <= 1'b0;
                state           <= RST;
              end else begin
                state <= DONE;
              end
            end else if (sel_stat) begin
              d_oe_q  <= 1'b1;
              d_out_q <= stat_byte;
              state   <= RD_STAT;
            end
          end
        end

        WR_SI: begin
          if (cnt == 8'd0) begin
            host_fifo_si <= 1'b0;
            state        <= DONE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        RD_DATA: begin
          if (rd_s || iorq_s) begin
            host_fifo_oeb <= 1'b1;
            host_fifo_sob <= 1'b0;
            cnt           <= 8'(SOB_CYCLES - 1);
            state         <= RD_SOB;
          end
        end

        RD_SOB: begin
          if (cnt == 8'd0) begin
            host_fifo_sob <= 1'b1;
            state         <= DONE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        RD_STAT: begin
          if (rd_s || iorq_s) begin
            d_oe_q  <= 1'b0;
            d_out_q <= '0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
            state   <= DONE;
          end
        end

        RST: begin
          if (mr_cnt == 8'd0) state <= DONE;
        end

        DONE: begin
          if (iorq_s) begin
            d_oe_q  <= 1'b0;
            d_out_q <= '0;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpc_fifo_host_ctrl.sv
// Self-checking bench for cpc_fifo_host_ctrl with a behavioural FIFO chip
// and a queue-based reference of FIFO contents and sticky flags.
module tb_cpc_fifo_host_ctrl;

  localparam int DEPTH = 4;

  logic CLK = 1'b0;
  logic RESET_B;
  logic host_fifo_si, host_fifo_sob, host_fifo_oeb, host_fifo_reset;
  logic fifo_host_dir, fifo_host_dor;
  logic dir_lo;

  int n_tests = 0;
  int n_fail  = 0;

  cpc_fifo_host_ctrl_if bus_if ();

  cpc_fifo_host_ctrl dut (
    .CLK             (CLK),
    .RESET_B         (RESET_B),
    .bus             (bus_if),
    .fifo_host_dir   (fifo_host_dir),
    .fifo_host_dor   (fifo_host_dor),
    .host_fifo_si    (host_fifo_si),
    .host_fifo_sob   (host_fifo_sob),
    .host_fifo_oeb   (host_fifo_oeb),
    .host_fifo_reset (host_fifo_reset)
  );

  always #125 CLK = ~CLK;

  // Behavioural FIFO chip
  logic [7:0] fq[$];
  int         fq_n = 0;
  logic       si_p = 1'b0, sob_p = 1'b1;
  always @(negedge CLK) begin
    if (host_fifo_reset) fq.delete();
    else begin
      if (host_fifo_si && !si_p && fq.size() < DEPTH) fq.push_back(bus_if.D_IN);
      if (host_fifo_sob && !sob_p && fq.size() > 0) void'(fq.pop_front());
    end
    fq_n  = fq.size();
    si_p  = host_fifo_si;
    sob_p = host_fifo_sob;
  end
  assign fifo_host_dir = !dir_lo && (fq_n < DEPTH);
  assign fifo_host_dor = (fq_n > 0);

  // Strobe monitor: running totals, read as differences
  int si_hi = 0, si_pul = 0, sob_lo = 0, sob_pul = 0, mr_hi = 0, oeb_lo = 0, ovl = 0, rdy_lo = 0;
  logic m_si = 1'b0, m_sob = 1'b1;
  always @(negedge CLK) begin
    if (RESET_B) begin
      if (host_fifo_si) si_hi <= si_hi + 1;
      if (host_fifo_si && !m_si) si_pul <= si_pul + 1;
      if (!host_fifo_sob) sob_lo <= sob_lo + 1;
      if (!host_fifo_sob && m_sob) sob_pul <= sob_pul + 1;
      if (host_fifo_reset) mr_hi <= mr_hi + 1;
      if (!host_fifo_oeb) oeb_lo <= oeb_lo + 1;
      if (!host_fifo_oeb && bus_if.D_OE) ovl <= ovl + 1;
      if (!bus_if.READY) rdy_lo <= rdy_lo + 1;
    end
    m_si  <= host_fifo_si;
    m_sob <= host_fifo_sob;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    n_tests++;
    assert (obs >= lo && obs <= hi) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // One Z80 I/O cycle; returns the byte on the data bus near the end of it
  task automatic io(input bit wr, input logic [15:0] addr, input logic [7:0] wdat,
                    output logic [7:0] rdat);
    int w;
    @(posedge CLK); #2;
    bus_if.A       = addr;
    bus_if.D_IN    = wdat;
    bus_if.IOREQ_B = 1'b0;
    if (wr) bus_if.WR_B = 1'b0; else bus_if.RD_B = 1'b0;
    repeat (5) @(negedge CLK);
    w = 0;
    while (bus_if.READY !== 1'b1 && w < 400) begin @(negedge CLK); w++; end
    if (w >= 400) chk("ready_bound", w, 0);
    repeat (4) @(negedge CLK);
    if (!host_fifo_oeb) rdat = (fq.size() > 0) ? fq[0] : 8'hEE;
    else if (bus_if.D_OE) rdat = bus_if.D_OUT;
    else rdat = 8'hFF;
    @(posedge CLK); #2;
    bus_if.IOREQ_B = 1'b1;
    bus_if.RD_B    = 1'b1;
    bus_if.WR_B    = 1'b1;
    repeat (14) @(posedge CLK);
  endtask

  // Reference model state
  logic [7:0] rq[$];
  bit         r_ovf = 1'b0, r_unf = 1'b0;

  function automatic logic [7:0] exp_stat();
    logic [7:0] s;
    s = 8'h00;
    if (r_ovf) s = s | 8'h80;
    if (r_unf) s = s | 8'h40;
    if (rq.size() < DEPTH) s = s | 8'h02;
    if (rq.size() > 0) s = s | 8'h01;
    return s;
  endfunction

  localparam logic [15:0] DP = 16'hFD80;
  localparam logic [15:0] SP = 16'hFD81;

  initial begin
    logic [7:0] rd, ev;
    int b_si, b_sih, b_sob, b_sobl, b_mr, b_oe, b_rdy;

    bus_if.A = '0; bus_if.D_IN = '0;
    bus_if.IOREQ_B = 1'b1; bus_if.RD_B = 1'b1; bus_if.WR_B = 1'b1;
    dir_lo  = 1'b0;
    RESET_B = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    chk("rst_si", host_fifo_si, 0);
    chk("rst_sob", host_fifo_sob, 1);
    chk("rst_oeb", host_fifo_oeb, 1);
    chk("rst_mr", host_fifo_reset, 1);
    chk("rst_doe", bus_if.D_OE, 0);
    chk("rst_dout", bus_if.D_OUT, 0);
    chk("rst_ready", bus_if.READY, 1);

    // Release: MR must stay high exactly RST_CYCLES cycles
    @(posedge CLK); #2; RESET_B = 1'b1;
    @(posedge CLK); #2; b_mr = mr_hi;
    repeat (10) @(posedge CLK);
    chk("por_mr_width", mr_hi - b_mr, 4);

    io(0, SP, 8'h00, rd);
    chk("stat_empty", rd, 8'h02);

    // Write 0x5A with space available
    b_si = si_pul; b_sih = si_hi;
    io(1, DP, 8'h5A, rd);
    chk("wr_si_pulses", si_pul - b_si, 1);
    chk("wr_si_width", si_hi - b_sih, 2);
    chk("wr_fifo_n", fq_n, 1);
    chk("wr_fifo_head", (fq_n > 0) ? fq[0] : 8'h00, 8'h5A);
    io(0, SP, 8'h00, rd);
    chk("stat_one", rd, 8'h03);

    // Read it back
    b_sob = sob_pul; b_sobl = sob_lo; b_oe = oeb_lo;
    io(0, DP, 8'h00, rd);
    chk("rd_data", rd, 8'h5A);
    chk("rd_sob_pulses", sob_pul - b_sob, 1);
    chk("rd_sob_width", sob_lo - b_sobl, 2);
    chk_rng("rd_oeb_low", oeb_lo - b_oe, 3, 12);
    chk("rd_dor_fall", fifo_host_dor, 0);

    // Write with no space -> OVF
    dir_lo = 1'b1;
    b_si = si_pul; b_rdy = rdy_lo;
    io(1, DP, 8'h11, rd);
    chk("ovf_no_si", si_pul - b_si, 0);
`ifdef CPC_FIFO_WAIT_EN
    chk_rng("ovf_wait_len", rdy_lo - b_rdy, 250, 262);
`else
    chk("ovf_ready_high", rdy_lo - b_rdy, 0);
`endif
    io(0, SP, 8'h00, rd);
    chk("stat_ovf", rd, 8'h80);
    io(0, SP, 8'h00, rd);
    chk("stat_ovf_clr", rd, 8'h00);
    dir_lo = 1'b0;

    // Read while empty -> 0xFF, UNF
    b_sob = sob_pul; b_oe = oeb_lo;
    io(0, DP, 8'h00, rd);
    chk("unf_bus_ff", rd, 8'hFF);
    chk("unf_no_sob", sob_pul - b_sob, 0);
    chk("unf_no_oeb", oeb_lo - b_oe, 0);
    io(0, SP, 8'h00, rd);
    chk("stat_unf", rd, 8'h42);

    // UNF again, then clear via control write with MR
    io(0, DP, 8'h00, rd);
    b_mr = mr_hi;
    io(1, SP, 8'h80, rd);
    chk("ctrl_mr_width", mr_hi - b_mr, 4);
    io(0, SP, 8'h00, rd);
    chk("ctrl_flags_clr", rd, 8'h02);

    // Control write without bit 7, foreign address
    b_mr = mr_hi; b_si = si_pul;
    io(1, SP, 8'h7F, rd);
    io(1, 16'hFD82, 8'h33, rd);
    chk("ctrl_noop_mr", mr_hi - b_mr, 0);
    chk("foreign_no_si", si_pul - b_si, 0);

`ifdef CPC_FIFO_WAIT_EN
    // Space appears ~10 cycles into the wait
    dir_lo = 1'b1;
    b_si = si_pul; b_rdy = rdy_lo;
    fork
      begin repeat (11) @(posedge CLK); #2 dir_lo = 1'b0; end
    join_none
    io(1, DP, 8'hA5, rd);
    chk_rng("wait_len", rdy_lo - b_rdy, 5, 16);
    chk("wait_si_pulses", si_pul - b_si, 1);
    io(0, SP, 8'h00, rd);
    chk("wait_stat_no_ovf", rd, 8'h03);
    io(0, DP, 8'h00, rd);
    chk("wait_rd_data", rd, 8'hA5);
`endif

    // Reset in the middle of an si pulse
    dir_lo = 1'b0;
    @(posedge CLK); #2;
    bus_if.A = DP; bus_if.D_IN = 8'h77; bus_if.IOREQ_B = 1'b0; bus_if.WR_B = 1'b0;
    begin
      int t;
      t = 0;
      while (host_fifo_si !== 1'b1 && t < 20) begin @(negedge CLK); t++; end
      if (t >= 20) chk("midsi_bound", t, 0);
    end
    RESET_B = 1'b0;
    @(negedge CLK);
    chk("midsi_si_drop", host_fifo_si, 0);
    chk("midsi_mr", host_fifo_reset, 1);
    bus_if.IOREQ_B = 1'b1; bus_if.WR_B = 1'b1;
    repeat (2) @(posedge CLK); #2;
    RESET_B = 1'b1;
    repeat (12) @(posedge CLK);
    io(0, SP, 8'h00, rd);
    chk("midsi_stat", rd, 8'h02);

    // Randomised traffic against the reference queue
    rq.delete(); r_ovf = 0; r_unf = 0;
    for (int i = 0; i < 30; i++) begin
      int op;
      logic [7:0] wd;
      op = $urandom_range(0, 3);
      wd = 8'($urandom);
      if (op <= 1) begin
        b_si = si_pul;
        io(1, DP, wd, rd);
        if (rq.size() < DEPTH) begin rq.push_back(wd); chk("rnd_si", si_pul - b_si, 1); end
        else begin r_ovf = 1; chk("rnd_no_si", si_pul - b_si, 0); end
      end else if (op == 2) begin
        io(0, DP, 8'h00, rd);
        if (rq.size() > 0) ev = rq.pop_front();
        else begin ev = 8'hFF; r_unf = 1; end
        chk("rnd_rd", rd, ev);
      end else begin
        ev = exp_stat();
        io(0, SP, 8'h00, rd);
        chk("rnd_stat", rd, ev);
        r_ovf = 0; r_unf = 0;
      end
    end

    chk("oeb_doe_overlap", ovl, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
